// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID pipeline register, with stall hold, redirect flush and fetch counting.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic [31:0]        imem_instr,
    output logic [31:0]        imem_addr,
    output logic [31:0]        pc_current,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc_plus4,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    redirect_pc;
    if_id_t             if_id_q;
    logic [COUNT_W-1:0] count_q;

    // PC arithmetic wraps modulo 2^32; redirect targets are silently word-aligned.
    assign pc_plus4    = pc_q + XLEN'(4);
    assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};

    // Priority: reset, then redirect (beats stall), then stall hold, else advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.valid    <= 1'b0;
            count_q          <= '0;
        end else if (branch_taken) begin
            pc_q             <= redirect_pc;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.valid    <= 1'b0;
        end else if (!stall) begin
            pc_q             <= pc_plus4;
            if_id_q.pc       <= pc_q;
            if_id_q.pc_plus4 <= pc_plus4;
            if_id_q.instr    <= imem_instr;
            if_id_q.valid    <= 1'b1;
            count_q          <= count_q + COUNT_W'(1);
        end
    end

    assign imem_addr      = pc_q;
    assign pc_current     = pc_q;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_valid    = if_id_q.valid;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic,
// every cycle compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [31:0] branch_target, imem_instr, imem_addr, pc_current;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];

    // reference model state
    logic [31:0] m_pc, m_ipc, m_ip4, m_ins, m_cnt;
    logic        m_v;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .pc_current(pc_current), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Program in low 256 bytes; everything above reads an address-derived pattern.
    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        logic [5:0] idx;
        idx = addr[7:2];
        if (addr < 32'd256) return mem[idx];
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    always_comb imem_instr = mem_read(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        if (r) begin
            m_pc = RESET_PC; m_ipc = 0; m_ip4 = 0; m_ins = NOP_INSTR; m_v = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = (t / 4) * 4; m_ipc = 0; m_ip4 = 0; m_ins = NOP_INSTR; m_v = 0;
        end else if (!s) begin
            m_ins = mem_read(m_pc); m_ipc = m_pc; m_ip4 = m_pc + 4; m_v = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        chk("pc_current", pc_current, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_ip4);
        chk("if_id_instr", if_id_instr, m_ins);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        m_pc = 0; m_ipc = 0; m_ip4 = 0; m_ins = 0; m_v = 0; m_cnt = 0;

        // reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_instr", if_id_instr, 32'h0000_0013);
        chk("reset_pc", pc_current, 32'h0);

        // free run over the three-instruction program
        step(0, 0, 0, 0);
        chk("run1_instr", if_id_instr, 32'h0050_0093);
        step(0, 0, 0, 0);
        chk("run2_instr", if_id_instr, 32'h00A0_0113);
        chk("run2_pc", pc_current, 32'd8);

        // stall three cycles at pc 8, then release
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("stall_pc", pc_current, 32'd8);
        chk("stall_ifid_pc", if_id_pc, 32'd4);
        chk("stall_count", fetch_count, 32'd2);
        step(0, 0, 0, 0);
        chk("release_ifid_pc", if_id_pc, 32'd8);
        chk("release_instr", if_id_instr, 32'h0020_81B3);
        chk("release_count", fetch_count, 32'd3);
        step(0, 0, 0, 0);
        chk("pre_branch_pc", pc_current, 32'h10);

        // redirect to 0x20
        step(0, 0, 1, 32'h20);
        chk("br_pc", pc_current, 32'h20);
        chk("br_valid", {31'b0, if_id_valid}, 32'd0);
        chk("br_count", fetch_count, 32'd4);
        step(0, 0, 0, 0);
        chk("br_target_ifid_pc", if_id_pc, 32'h20);
        chk("br_target_valid", {31'b0, if_id_valid}, 32'd1);

        // redirect with simultaneous stall and misaligned target
        step(0, 1, 1, 32'h23);
        chk("brstall_pc", pc_current, 32'h20);
        chk("brstall_instr", if_id_instr, 32'h0000_0013);

        // reset mid-run beats stall and redirect
        step(0, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        chk("midrst_pc", pc_current, RESET_PC);
        chk("midrst_count", fetch_count, 32'd0);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_pc", pc_current, 32'h0);
        chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", if_id_pc_plus4, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            step(r, s, b, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
